// File: rtl/powlib_cntr_pkg.sv
// Shared powlib helper functions used across the counter slice.
package powlib_cntr_pkg;

  // Bits needed to index 'value' entries (minimum 1).
  function automatic int unsigned powlib_clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [31:0] powlib_grayencode(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Generic W-bit state register with synchronous reset and optional enable.
module powlib_flipflop #(
  parameter int unsigned W    = 1,
  parameter int          INIT = 0,
  parameter bit          EVLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] INIT_W = W'(INIT);

  // Reset to INIT; otherwise capture d when enabled (or every cycle if EVLD=0).
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT_W;
    end else if (!EVLD || vld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/powlib_cntr.sv
// Up/down counter with clear, optional load and optional external step.
// Optional simulation checks are compiled in when POWLIB_CNTR_CHECKS_EN is defined.
module powlib_cntr
  import powlib_cntr_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int          X    = 1,
  parameter int          INIT = 0,
  parameter int          ELD  = 1,
  parameter int          EDX  = 0,
  parameter int          EAR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cntr,
  input  logic         adv,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] nval,
  input  logic [W-1:0] dx
);

  localparam logic [W-1:0] X_W    = W'(X);
  localparam logic [W-1:0] INIT_W = W'(INIT);
  localparam bit           LD_EN  = (ELD != 0);
  localparam bit           DX_EN  = (EDX != 0);

  logic [W-1:0] step_c;
  logic [W-1:0] nxt_c;
  logic         ld_c;
  logic         vld_c;

  // EAR is kept for instantiation compatibility; reset is always synchronous.
  if (EAR != 0) begin : g_ear_compat
  end

  // Inputs that a given configuration ignores are folded into a sink.
  logic unused_in;
  assign unused_in = ^{dx, nval, ld};

  // Next-state and enable: clr beats ld, ld beats adv; rst is handled in the register.
  always_comb begin
    step_c = X_W;
    nxt_c  = cntr;
    ld_c   = 1'b0;
    vld_c  = 1'b0;
    if (DX_EN) begin
      step_c = dx;
    end
    ld_c  = LD_EN && ld;
    vld_c = clr || ld_c || adv;
    if (clr) begin
      nxt_c = INIT_W;
    end else if (ld_c) begin
      nxt_c = nval;
    end else begin
      nxt_c = cntr + step_c;
    end
  end

  powlib_flipflop #(
    .W    (W),
    .INIT (INIT),
    .EVLD (1'b1)
  ) u_state (
    .clk (clk),
    .rst (rst),
    .vld (vld_c),
    .d   (nxt_c),
    .q   (cntr)
  );

`ifdef POWLIB_CNTR_CHECKS_EN
  // Elaboration sanity checks on the configuration.
  initial begin
    if (W < 1) begin
      $display("powlib_cntr: fatal: W must be at least 1 (W=%0d)", W);
      $finish;
    end
    if ((ELD != 0 && ELD != 1) || (EDX != 0 && EDX != 1)) begin
      $display("powlib_cntr: fatal: ELD and EDX must be 0 or 1 (ELD=%0d EDX=%0d)", ELD, EDX);
      $finish;
    end
  end

  // Warn when clear and load collide; clear wins.
  always @(posedge clk) begin
    if (!rst && ld && clr) begin
      $display("powlib_cntr: warning: ld and clr asserted together at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_powlib_cntr.sv
// Scoreboard bench for powlib_cntr across several parameter sets sharing one stimulus.
module tb_powlib_cntr;

  localparam int N = 7;
  localparam int PW   [N] = '{3, 3, 4, 8, 4, 4, 8};
  localparam int PX   [N] = '{1, 1, 1, 1, 1, 1, 3};
  localparam int PI   [N] = '{0, 0, 1, 0, 3, 0, 0};
  localparam int PELD [N] = '{1, 1, 1, 1, 1, 1, 0};
  localparam int PEDX [N] = '{0, 1, 0, 0, 0, 1, 0};

  logic       clk;
  logic       rst;
  logic       clr;
  logic       ld;
  logic       adv;
  logic [7:0] nval;
  logic [7:0] dx;

  logic [2:0] c0;
  logic [2:0] c1;
  logic [3:0] c2;
  logic [7:0] c3;
  logic [3:0] c4;
  logic [3:0] c5;
  logic [7:0] c6;

  logic [7:0] obs [N];
  logic [7:0] mdl [N];
  logic [N*8-1:0] sb_q [$];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  powlib_cntr #(.W(3), .X(1), .INIT(0), .ELD(1), .EDX(0)) u0 (
    .clk(clk), .rst(rst), .cntr(c0), .adv(adv), .clr(clr), .ld(ld), .nval(nval[2:0]), .dx(dx[2:0]));
  powlib_cntr #(.W(3), .X(1), .INIT(0), .ELD(1), .EDX(1)) u1 (
    .clk(clk), .rst(rst), .cntr(c1), .adv(adv), .clr(clr), .ld(ld), .nval(nval[2:0]), .dx(dx[2:0]));
  powlib_cntr #(.W(4), .X(1), .INIT(1), .ELD(1), .EDX(0)) u2 (
    .clk(clk), .rst(rst), .cntr(c2), .adv(adv), .clr(clr), .ld(ld), .nval(nval[3:0]), .dx(dx[3:0]));
  powlib_cntr #(.W(8), .X(1), .INIT(0), .ELD(1), .EDX(0)) u3 (
    .clk(clk), .rst(rst), .cntr(c3), .adv(adv), .clr(clr), .ld(ld), .nval(nval), .dx(dx));
  powlib_cntr #(.W(4), .X(1), .INIT(3), .ELD(1), .EDX(0)) u4 (
    .clk(clk), .rst(rst), .cntr(c4), .adv(adv), .clr(clr), .ld(ld), .nval(nval[3:0]), .dx(dx[3:0]));
  powlib_cntr #(.W(4), .X(1), .INIT(0), .ELD(1), .EDX(1)) u5 (
    .clk(clk), .rst(rst), .cntr(c5), .adv(adv), .clr(clr), .ld(ld), .nval(nval[3:0]), .dx(dx[3:0]));
  powlib_cntr #(.W(8), .X(3), .INIT(0), .ELD(0), .EDX(0)) u6 (
    .clk(clk), .rst(rst), .cntr(c6), .adv(adv), .clr(clr), .ld(ld), .nval(nval), .dx(dx));

  always_comb begin
    obs[0] = 8'(c0);
    obs[1] = 8'(c1);
    obs[2] = 8'(c2);
    obs[3] = c3;
    obs[4] = 8'(c4);
    obs[5] = 8'(c5);
    obs[6] = c6;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one counter for one edge.
  function automatic logic [7:0] ref_next(input int i, input logic [7:0] cur,
                                          input logic r, input logic c, input logic l,
                                          input logic [7:0] nv, input logic a, input logic [7:0] d);
    logic [7:0] mask;
    logic [7:0] step;
    mask = 8'((1 << PW[i]) - 1);
    step = (PEDX[i] == 1) ? d : 8'(PX[i]);
    if (r)                      return 8'(PI[i]) & mask;
    else if (c)                 return 8'(PI[i]) & mask;
    else if (PELD[i] == 1 && l) return nv & mask;
    else if (a)                 return (cur + step) & mask;
    else                        return cur;
  endfunction

  // Drive one cycle, push expected values, then pop and compare after the edge.
  task automatic cyc(input logic r, input logic c, input logic l, input logic [7:0] nv,
                     input logic a, input logic [7:0] d);
    logic [N*8-1:0] e;
    logic [N*8-1:0] p;
    rst = r; clr = c; ld = l; nval = nv; adv = a; dx = d;
    for (int i = 0; i < N; i++) begin
      mdl[i] = ref_next(i, mdl[i], r, c, l, nv, a, d);
      e[i*8 +: 8] = mdl[i];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    p = sb_q.pop_front();
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d", i), obs[i], p[i*8 +: 8]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < N; i++) mdl[i] = 8'h00;
    rst = 1'b0; clr = 1'b0; ld = 1'b0; adv = 1'b0; nval = 8'h00; dx = 8'h00;

    // Reset pulse: every counter at its INIT.
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    check("rst_u2_init", obs[2], 8'd1);
    check("rst_u4_init", obs[4], 8'd3);

    // Nine advances, dx = -1 for the dx-driven counters.
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 8'h00, 1, 8'hFF);
    check("u0_wrap", obs[0], 8'd1);
    check("u1_down", obs[1], 8'd7);
    check("u6_x3", obs[6], 8'd27);

    // Load with adv: load wins; ELD=0 instance ignores the load.
    cyc(0, 0, 1, 8'hA5, 1, 8'h01);
    check("u3_load", obs[3], 8'hA5);
    check("u6_noload", obs[6], 8'd30);
    cyc(0, 0, 0, 8'h00, 1, 8'h01);
    check("u3_after_load", obs[3], 8'hA6);

    // Clear with adv: clear wins.
    cyc(0, 1, 0, 8'h00, 1, 8'h01);
    check("u2_clr", obs[2], 8'd1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 8'h00, 1, 8'h01);
    check("u2_cnt5", obs[2], 8'd5);

    // Reset mid-count overrides everything, counting resumes after.
    cyc(1, 1, 1, 8'h0C, 1, 8'h01);
    check("u4_rst_all", obs[4], 8'd3);
    cyc(0, 0, 0, 8'h00, 1, 8'h01);
    check("u4_resume", obs[4], 8'd4);

    // Hold with dx=5 and adv=0, then adv with dx=0.
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 8'h00, 0, 8'h05);
    check("u5_hold", obs[5], 8'd1);
    cyc(0, 0, 0, 8'h00, 1, 8'h00);
    check("u5_dx0", obs[5], 8'd1);

    // Random traffic against the reference.
    for (int k = 0; k < 200; k++) begin
      cyc(($urandom_range(19) == 0), ($urandom_range(9) == 0), ($urandom_range(5) == 0),
          8'($urandom), ($urandom_range(3) != 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
